uart_tx_cfg: RTL and testbench

Parametrised, buffered UART transmitter; next generation of the single-byte SoC UART TX.
Adds a small TX FIFO, compile-time data width, and run-time parity and stop-bit configuration.
Sits between the bus-side UART register block, which writes words with valid/ready, and the o_uart_tx pin.
Frames are sent back-to-back while the FIFO holds data.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 51 +++++
 rtl/uart_tx_cfg.sv | 120 ++++++++++++
 tb/tb_uart_tx_cfg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and divisor helpers for the buffered UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Frame options captured when a word leaves the FIFO.
  typedef struct packed {
    logic parity_en;
    logic two_stop;
  } frame_cfg_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_cnt_w(input int clk_hz, input int baud);
    return $clog2(clk_hz / baud) + 1;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with an explicitly tracked fill level.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [LW-1:0]               level;
  logic                        do_push, do_pop;

  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];
  assign o_level = level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: FIFO in front of a frame FSM with run-time
// parity and stop-bit options latched per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter  int clk_freq_hz = 30000000,
  parameter  int baud_rate   = 115200,
  parameter  int data_bits   = 8,
  parameter  int fifo_depth  = 4,
  localparam int LW          = $clog2(fifo_depth) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [data_bits-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic                 o_uart_tx,
  output logic                 o_busy,
  output logic [LW-1:0]        o_fifo_level
);
  localparam int DIV   = calc_div(clk_freq_hz, baud_rate);
  localparam int CNT_W = calc_cnt_w(clk_freq_hz, baud_rate);
  localparam int IW    = $clog2(data_bits + 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

  state_t               state;
  frame_cfg_t           cfg;
  logic [CNT_W-1:0]     cnt;
  logic [IW-1:0]        bit_idx;
  logic [data_bits-1:0] shreg, fifo_dout;
  logic                 parity_bit, stop_second, tx;
  logic                 fifo_full, fifo_empty, push, pop, bit_end;

  assign bit_end = (cnt == '0);
  assign push    = i_valid & ~fifo_full;
  // Pop from idle, or at the end of the last stop bit so frames abut.
  assign pop     = ~fifo_empty &
                   ((state == IDLE) | ((state == STOP) & bit_end & ~stop_second));

  uart_sync_fifo #(.WIDTH(data_bits), .DEPTH(fifo_depth)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_data),
    .o_data  (fifo_dout),
    .o_level (o_fifo_level),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cfg         <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      stop_second <= 1'b0;
      tx          <= 1'b1;
    end else if (pop) begin
      state      <= START;
      tx         <= 1'b0;
      cnt        <= DIV_M1;
      shreg      <= fifo_dout;
      cfg        <= '{parity_en: i_parity_en, two_stop: i_two_stop};
      parity_bit <= ^fifo_dout ^ i_parity_odd;
    end else begin
      if (!bit_end) cnt <= cnt - 1'b1;
      case (state)
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shreg[0];
          cnt     <= DIV_M1;
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          cnt <= DIV_M1;
          if (bit_idx == IW'(data_bits - 1)) begin
            if (cfg.parity_en) begin
              state <= PARITY;
              tx    <= parity_bit;
            end else begin
              state       <= STOP;
              tx          <= 1'b1;
              stop_second <= cfg.two_stop;
            end
          end else begin
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
            bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: if (bit_end) begin
          state       <= STOP;
          tx          <= 1'b1;
          cnt         <= DIV_M1;
          stop_second <= cfg.two_stop;
        end
        STOP: if (bit_end) begin
          if (stop_second) begin
            stop_second <= 1'b0;
            cnt         <= DIV_M1;
          end else begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_uart_tx = tx;
  assign o_ready   = ~fifo_full;
  assign o_busy    = (state != IDLE) | ~fifo_empty;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg at DIV=10: frame shapes, parity, stop bits,
// back-to-back streaming, mid-frame config change, reset abort, 5-bit build.
module tb_uart_tx_cfg;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic [4:0] data5;
  logic       valid, valid5, pe, po, ts;
  logic       ready, tx, busy, ready5, tx5, busy5;
  logic [2:0] level, level5;

  int pass_cnt = 0;
  int total    = 0;

  logic cap_tx   [0:703];
  logic cap_busy [0:703];
  int   cap_lvl  [0:703];
  logic exp_bits [0:63];
  int   exp_n;

  always #5 clk = ~clk;

  uart_tx_cfg #(.clk_freq_hz(1000000), .baud_rate(100000), .data_bits(8), .fifo_depth(4)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_parity_en(pe), .i_parity_odd(po), .i_two_stop(ts),
    .o_uart_tx(tx), .o_busy(busy), .o_fifo_level(level));

  uart_tx_cfg #(.clk_freq_hz(1000000), .baud_rate(100000), .data_bits(5), .fifo_depth(4)) u5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data5), .i_valid(valid5), .o_ready(ready5),
    .i_parity_en(pe), .i_parity_odd(po), .i_two_stop(ts),
    .o_uart_tx(tx5), .o_busy(busy5), .o_fifo_level(level5));

  // Expected line bits are written in time order, first bit leftmost.
  task automatic set_exp(input logic [63:0] v, input int n);
    exp_n = n;
    for (int k = 0; k < n; k++) exp_bits[k] = v[n-1-k];
  endtask

  function automatic int frame_errs();
    int e = 0;
    for (int k = 0; k < exp_n; k++)
      for (int j = 0; j < 10; j++)
        if (cap_tx[10*k+j] !== exp_bits[k]) e++;
    return e;
  endfunction

  task automatic capture(input bit sel, input int n, output int waited);
    waited = 0;
    while ((sel ? tx5 : tx) !== 1'b0 && waited < 300) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 300) begin
      waited = -1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      cap_tx[i]   = sel ? tx5 : tx;
      cap_busy[i] = sel ? busy5 : busy;
      cap_lvl[i]  = sel ? int'(level5) : int'(level);
    end
  endtask

  task automatic push_word(input bit sel, input logic [7:0] d);
    int   guard = 0;
    logic r;
    if (sel) begin data5 = d[4:0]; valid5 = 1'b1; end
    else     begin data  = d;      valid  = 1'b1; end
    do begin
      r = sel ? ready5 : ready;
      @(posedge clk); #1; guard++;
    end while (!r && guard < 200);
    valid = 1'b0; valid5 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = '0; data5 = '0; valid = 1'b0; valid5 = 1'b0;
    pe = 1'b0; po = 1'b0; ts = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if (tx !== 1'b1)     $display("FAIL reset_tx: got %b want 1", tx);          else pass_cnt++;
    total++; if (ready !== 1'b1)  $display("FAIL reset_ready: got %b want 1", ready);    else pass_cnt++;
    total++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);      else pass_cnt++;
    total++; if (level !== 3'd0)  $display("FAIL reset_level: got %0d want 0", level);   else pass_cnt++;
    total++; if (tx5 !== 1'b1)    $display("FAIL reset_tx5: got %b want 1", tx5);        else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1();
    int w, bc = 0;
    set_exp(10'b0_10100101_1, 10);
    push_word(0, 8'hA5);
    capture(0, 101, w);
    for (int i = 0; i < 100; i++) if (cap_busy[i] === 1'b1) bc++;
    total++; if (w !== 1)             $display("FAIL 8n1_latency: got %0d want 1", w);       else pass_cnt++;
    total++; if (frame_errs() !== 0)  $display("FAIL 8n1_bits: got %0d bad samples want 0", frame_errs()); else pass_cnt++;
    total++; if (cap_tx[100] !== 1'b1) $display("FAIL 8n1_idle: got %b want 1", cap_tx[100]); else pass_cnt++;
    total++; if (bc !== 100)          $display("FAIL 8n1_busy_len: got %0d want 100", bc);   else pass_cnt++;
    total++; if (cap_busy[100] !== 1'b0) $display("FAIL 8n1_busy_end: got %b want 0", cap_busy[100]); else pass_cnt++;
  endtask

  task automatic test_parity();
    int w, len;
    for (int m = 0; m < 3; m++) begin
      pe = 1'b1;
      po = (m == 1);
      ts = (m == 2);
      case (m)
        0:       begin set_exp(11'b0_11100000_1_1,  11); len = 110; end
        1:       begin set_exp(11'b0_11100000_0_1,  11); len = 110; end
        default: begin set_exp(12'b0_11100000_1_11, 12); len = 120; end
      endcase
      push_word(0, 8'h07);
      capture(0, len + 1, w);
      total++; if (frame_errs() !== 0) $display("FAIL parity_bits_m%0d: got %0d bad samples want 0", m, frame_errs()); else pass_cnt++;
      total++;
      if (cap_busy[len-1] !== 1'b1 || cap_busy[len] !== 1'b0)
        $display("FAIL parity_len_m%0d: got busy %b%b at end want 10", m, cap_busy[len-1], cap_busy[len]);
      else pass_cnt++;
    end
    pe = 1'b0; po = 1'b0; ts = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w, ready_low = 0, full_ready = 0, maxl = 0;
    set_exp({10'b0_10000000_1, 10'b0_01000000_1, 10'b0_11000000_1,
             10'b0_00100000_1, 10'b0_10100000_1, 10'b0_01100000_1}, 60);
    fork
      begin
        int   k = 1, g = 0;
        logic r;
        data = 8'h01; valid = 1'b1;
        while (k <= 6 && g < 1000) begin
          r = ready;
          if (level == 3'd4 && ready) full_ready++;
          if (!ready) ready_low++;
          @(posedge clk); #1; g++;
          if (r) begin k++; data = 8'(k); end
        end
        valid = 1'b0;
      end
      capture(0, 601, w);
    join
    for (int i = 0; i < 601; i++) if (cap_lvl[i] > maxl) maxl = cap_lvl[i];
    total++; if (frame_errs() !== 0) $display("FAIL b2b_bits: got %0d bad samples want 0", frame_errs()); else pass_cnt++;
    total++; if (maxl !== 4)          $display("FAIL b2b_max_level: got %0d want 4", maxl);     else pass_cnt++;
    total++; if (ready_low == 0)      $display("FAIL b2b_ready_drop: got %0d low cycles want >0", ready_low); else pass_cnt++;
    total++; if (full_ready !== 0)    $display("FAIL b2b_ready_full: got %0d want 0", full_ready); else pass_cnt++;
    total++;
    if (cap_lvl[550] !== 0 || cap_busy[550] !== 1'b1)
      $display("FAIL b2b_drain: got level %0d busy %b want 0 1", cap_lvl[550], cap_busy[550]);
    else pass_cnt++;
    total++;
    if (cap_busy[599] !== 1'b1 || cap_busy[600] !== 1'b0 || cap_tx[600] !== 1'b1)
      $display("FAIL b2b_end: got busy %b%b tx %b want 10 1", cap_busy[599], cap_busy[600], cap_tx[600]);
    else pass_cnt++;
  endtask

  task automatic test_cfg_midframe();
    int w;
    set_exp({10'b0_00111100_1, 11'b0_00111100_0_1}, 21);
    push_word(0, 8'h3C);
    push_word(0, 8'h3C);
    fork
      capture(0, 211, w);
      begin repeat (30) @(posedge clk); #1; pe = 1'b1; end
    join
    total++; if (w !== 0)            $display("FAIL mid_align: got %0d want 0", w); else pass_cnt++;
    total++; if (frame_errs() !== 0) $display("FAIL mid_bits: got %0d bad samples want 0", frame_errs()); else pass_cnt++;
    total++;
    if (cap_busy[209] !== 1'b1 || cap_busy[210] !== 1'b0)
      $display("FAIL mid_len: got busy %b%b at end want 10", cap_busy[209], cap_busy[210]);
    else pass_cnt++;
    pe = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    push_word(0, 8'h55);
    push_word(0, 8'h66);
    push_word(0, 8'h77);
    repeat (34) @(posedge clk); #1;
    total++;
    if (busy !== 1'b1 || level !== 3'd2)
      $display("FAIL rst_pre: got busy %b level %0d want 1 2", busy, level);
    else pass_cnt++;
    rst_n = 1'b0; #1;
    total++; if (tx !== 1'b1)    $display("FAIL rst_tx: got %b want 1", tx);         else pass_cnt++;
    total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready);   else pass_cnt++;
    total++; if (level !== 3'd0) $display("FAIL rst_level: got %0d want 0", level);  else pass_cnt++;
    total++; if (busy !== 1'b0)  $display("FAIL rst_busy: got %b want 0", busy);     else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rst_after: got %0d active cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_5bit();
    int w;
    set_exp(7'b0_11111_1, 7);
    push_word(1, 8'h1F);
    capture(1, 71, w);
    total++; if (w !== 1)            $display("FAIL b5_latency: got %0d want 1", w); else pass_cnt++;
    total++; if (frame_errs() !== 0) $display("FAIL b5_bits: got %0d bad samples want 0", frame_errs()); else pass_cnt++;
    total++;
    if (cap_busy[69] !== 1'b1 || cap_busy[70] !== 1'b0 || cap_tx[70] !== 1'b1)
      $display("FAIL b5_len: got busy %b%b tx %b want 10 1", cap_busy[69], cap_busy[70], cap_tx[70]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_cfg_midframe();
    test_reset_midframe();
    test_5bit();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
